// File: rtl/macro_lane_tx.sv
// macro_lane_tx: buffers parallel words in a small FIFO and serializes each
// one as a sync beat plus WORD_W/4 nibble beats on four lanes feeding i1..i4.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   word handshake; in_data is the payload
//   lane_en             advance enable; 0 freezes the serializer
//   lane_o              lane bits, lane_o[0..3] drive i1..i4
//   sync_o / frame_o    sync beat / data beat markers
//   busy_o              FIFO non-empty or serializer active
//   word_cnt            wrapping count of transmitted words
module macro_lane_tx #(
    parameter int          WORD_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [3:0]  SYNC_PAT   = 4'b0110
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              lane_en,
    output logic [3:0]        lane_o,
    output logic              sync_o,
    output logic              frame_o,
    output logic              busy_o,
    output logic [15:0]       word_cnt
);

    localparam int BEATS = WORD_W / 4;
    localparam int BW    = $clog2(BEATS);
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              push;
    logic              pop;
    logic              empty;

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     beat_nxt;
    logic [WORD_W-1:0] shreg;
    logic              last_beat;
    logic              word_done;

    assign push      = in_valid && in_ready;
    assign empty     = (count == '0);
    assign last_beat = (beat == BW'(BEATS - 1));
    assign count_nxt = count
                     + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count    <= count_nxt;
            // Registered from occupancy: a pop while full does not
            // open the input in the same cycle.
            in_ready <= (count_nxt != (AW+1)'(FIFO_DEPTH));
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        pop       = 1'b0;
        word_done = 1'b0;
        if (lane_en) begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    state_nxt = DATA;
                    beat_nxt  = '0;
                end
                DATA: begin
                    if (last_beat) begin
                        word_done = 1'b1;
                        if (!empty) begin
                            pop       = 1'b1;
                            state_nxt = SYNC;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        beat_nxt = beat + BW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            shreg    <= '0;
            busy_o   <= 1'b0;
            word_cnt <= '0;
        end else begin
            state  <= state_nxt;
            beat   <= beat_nxt;
            busy_o <= (count_nxt != '0) || (state_nxt != IDLE);
            if (pop) begin
                shreg <= mem[rptr];
            end
            if (word_done) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

    // Lane outputs trail the state by one enabled edge and freeze with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_o  <= '0;
            sync_o  <= 1'b0;
            frame_o <= 1'b0;
        end else if (lane_en) begin
            unique case (state)
                SYNC: begin
                    lane_o  <= SYNC_PAT;
                    sync_o  <= 1'b1;
                    frame_o <= 1'b0;
                end
                DATA: begin
                    lane_o  <= shreg[{beat, 2'b00} +: 4];
                    sync_o  <= 1'b0;
                    frame_o <= 1'b1;
                end
                default: begin
                    lane_o  <= '0;
                    sync_o  <= 1'b0;
                    frame_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
